// File: rtl/tank_motion.sv
// Grid-locked tank position/heading controller: one keycode decision per video frame,
// then a glide of one full 32-px cell at STEP px per frame.
module tank_motion #(
  parameter int unsigned START_CX  = 0,
  parameter int unsigned START_CY  = 0,
  parameter int unsigned STEP      = 4,
  parameter logic [7:0]  KEY_UP    = 8'h1A,
  parameter logic [7:0]  KEY_LEFT  = 8'h04,
  parameter logic [7:0]  KEY_DOWN  = 8'h16,
  parameter logic [7:0]  KEY_RIGHT = 8'h07
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic [9:0] OtherX,
  input  logic [9:0] OtherY,
  output logic [9:0] TankX,
  output logic [9:0] TankY,
  output logic [1:0] TankDir,
  output logic       Moving
);

  localparam logic [9:0] START_X  = 10'(START_CX * 32);
  localparam logic [9:0] START_Y  = 10'(START_CY * 32);
  localparam logic [9:0] STEP_PX  = 10'(STEP);
  localparam logic [5:0] STEP_REM = 6'(STEP);
  localparam logic [5:0] CELL_PX  = 6'd32;

  typedef enum logic {IDLE = 1'b0, MOVE = 1'b1} state_t;

  state_t     state_reg, state_next;
  logic [9:0] x_reg, x_next;
  logic [9:0] y_reg, y_next;
  logic [1:0] dir_reg, dir_next;
  logic [5:0] remaining_reg, remaining_next;
  logic       frame_sync_reg, frame_clk_q;
  logic       tick;

  logic       key_valid;
  logic [1:0] key_dir;
  logic [4:0] cur_col, cur_row, tgt_col, tgt_row;
  logic       off_grid, blocked;

  // frame_clk is sampled once before edge detection, so a frame strobe acts on the
  // second Clk edge after it rises.
  assign tick = frame_sync_reg & ~frame_clk_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg      <= IDLE;
      x_reg          <= START_X;
      y_reg          <= START_Y;
      dir_reg        <= 2'b00;
      remaining_reg  <= 6'd0;
      frame_sync_reg <= 1'b0;
      frame_clk_q    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      x_reg          <= x_next;
      y_reg          <= y_next;
      dir_reg        <= dir_next;
      remaining_reg  <= remaining_next;
      frame_sync_reg <= frame_clk;
      frame_clk_q    <= frame_sync_reg;
    end
  end

  always_comb begin
    key_valid = 1'b1;
    key_dir   = 2'b00;
    if (keycode == KEY_UP)         key_dir = 2'b00;
    else if (keycode == KEY_RIGHT) key_dir = 2'b01;
    else if (keycode == KEY_DOWN)  key_dir = 2'b10;
    else if (keycode == KEY_LEFT)  key_dir = 2'b11;
    else                           key_valid = 1'b0;
  end

  assign cur_col = x_reg[9:5];
  assign cur_row = y_reg[9:5];

  always_comb begin
    tgt_col  = cur_col;
    tgt_row  = cur_row;
    off_grid = 1'b0;
    unique case (key_dir)
      2'b00: begin off_grid = (cur_row == 5'd0);  tgt_row = cur_row - 5'd1; end
      2'b01: begin off_grid = (cur_col == 5'd19); tgt_col = cur_col + 5'd1; end
      2'b10: begin off_grid = (cur_row == 5'd14); tgt_row = cur_row + 5'd1; end
      2'b11: begin off_grid = (cur_col == 5'd0);  tgt_col = cur_col - 5'd1; end
    endcase
    blocked = off_grid ||
              (({5'b0, tgt_col} == (OtherX >> 5)) && ({5'b0, tgt_row} == (OtherY >> 5)));
  end

  always_comb begin
    state_next     = state_reg;
    x_next         = x_reg;
    y_next         = y_reg;
    dir_next       = dir_reg;
    remaining_next = remaining_reg;
    if (tick) begin
      unique case (state_reg)
        IDLE: begin
          // Heading follows the key even when the move itself is refused.
          if (key_valid) begin
            dir_next = key_dir;
            if (!blocked) begin
              state_next     = MOVE;
              remaining_next = CELL_PX;
            end
          end
        end
        MOVE: begin
          unique case (dir_reg)
            2'b00: y_next = y_reg - STEP_PX;
            2'b01: x_next = x_reg + STEP_PX;
            2'b10: y_next = y_reg + STEP_PX;
            2'b11: x_next = x_reg - STEP_PX;
          endcase
          remaining_next = remaining_reg - STEP_REM;
          if (remaining_reg == STEP_REM) state_next = IDLE;
        end
      endcase
    end
  end

  assign TankX   = x_reg;
  assign TankY   = y_reg;
  assign TankDir = dir_reg;
  assign Moving  = (state_reg == MOVE);

endmodule
